// File: rtl/event_encoder_pkg.sv
// Shared constants for the encoder/decoder family: default line count and a
// constant-foldable ceil(log2) used to size index ports.
package event_encoder_pkg;

  localparam int DEFAULT_N = 8;

  // Returns at least 1 so that N=2 still gets a 1-bit index.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/event_encoder_prio_enc_n.sv
// N-input lowest-index-wins priority encoder; generalises the 8:3 one-hot
// encoder and additionally reports whether any input bit is set.
module prio_enc_n
  import event_encoder_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0]          vec_i,
  output logic [clog2(N)-1:0]   idx_o,
  output logic                  any_o
);

  localparam int W = clog2(N);

  // Scan from the top down so the lowest set bit is the last writer.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = W'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/event_encoder.sv
// Captures request pulses into a pending register and serves one line per
// cycle over valid/ready. Define EVENT_ENCODER_ROUND_ROBIN_EN for rotating
// priority; the default build uses fixed lowest-index priority.
module event_encoder
  import event_encoder_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic                  enc_ready,
  output logic                  enc_valid,
  output logic [clog2(N)-1:0]   enc_idx,
  output logic [N-1:0]          pending,
  output logic                  overflow
);

  localparam int W = clog2(N);

  logic [N-1:0] pending_q, pending_d;
  logic         overflow_q, overflow_d;
  logic [N-1:0] served;
  logic [W-1:0] sel_idx;
  logic [W-1:0] u_idx;
  logic         u_any;
  logic         xfer;

  prio_enc_n #(.N(N)) u_prio_all (
    .vec_i (pending_q),
    .idx_o (u_idx),
    .any_o (u_any)
  );

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] last_q, last_d;
  logic [N-1:0] above_mask;
  logic [W-1:0] m_idx;
  logic         m_any;

  // Lines strictly above the last served index get first chance.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign above_mask[gi] = (W'(gi) > last_q);
  end

  prio_enc_n #(.N(N)) u_prio_above (
    .vec_i (pending_q & above_mask),
    .idx_o (m_idx),
    .any_o (m_any)
  );

  assign sel_idx = m_any ? m_idx : u_idx;
  assign last_d  = xfer ? enc_idx : last_q;

  always_ff @(posedge clk) begin
    if (rst) last_q <= W'(N - 1);
    else     last_q <= last_d;
  end
`else
  assign sel_idx = u_idx;
`endif

  assign enc_valid = u_any;
  assign enc_idx   = enc_valid ? sel_idx : '0;
  assign xfer      = enc_valid && enc_ready;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

  always_comb begin
    served = '0;
    if (xfer) served[enc_idx] = 1'b1;
  end

  // A request landing on a line that is being served counts as a fresh event.
  assign pending_d  = (pending_q & ~served) | req;
  assign overflow_d = |(req & pending_q & ~served);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
